// File: rtl/ika9958_vram_arbiter.sv
// ika9958_vram_arbiter: fixed-slot VRAM scheduler sharing one 128 KB port
// between display fetch, CPU port and command engine.
// Optional CPU stall statistics: define IKA9958_VRAM_STALL_STAT_EN.
module ika9958_vram_arbiter #(
  parameter int unsigned SLOT_LEN   = 8,
  parameter logic [3:0]  DISP_MASK  = 4'b0111,
  parameter int unsigned CMD_STARVE = 3
) (
  input  logic        i_XTAL1,
  input  logic        i_RST_n,
  input  logic        i_XTAL_NCEN,
  input  logic        i_LINE_SYNC,
  input  logic        i_DISP_ACTIVE,
  input  logic [16:0] i_DISP_ADDR,
  output logic        o_DISP_VALID,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [16:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_WDATA,
  output logic        o_CPU_ACK,
  input  logic        i_CMD_REQ,
  input  logic        i_CMD_WR,
  input  logic [16:0] i_CMD_ADDR,
  input  logic [7:0]  i_CMD_WDATA,
  output logic        o_CMD_ACK,
  output logic [7:0]  o_RDATA,
  output logic [16:0] o_VA,
  output logic [7:0]  o_VDO,
  input  logic [7:0]  i_VDI,
  output logic        o_VCS_n,
  output logic        o_VWE_n,
`ifdef IKA9958_VRAM_STALL_STAT_EN
  input  logic        i_STAT_CLR,
  output logic [15:0] o_CPU_STALL_CNT,
`endif
  output logic [1:0]  o_SLOT_OWNER
);

  localparam int unsigned PW = 4;
  localparam int unsigned SW = (CMD_STARVE < 2) ? 1 : $clog2(CMD_STARVE + 1);

  localparam logic [PW-1:0] PH_LAST    = PW'(SLOT_LEN - 1);
  localparam logic [PW-1:0] PH_REC     = PW'(SLOT_LEN - 2);
  localparam logic [PW-1:0] PH_CAP     = PW'(SLOT_LEN - 3);
  localparam logic [SW-1:0] STARVE_MAX = SW'(CMD_STARVE);

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_DISP = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_CMD  = 2'd3;

  logic [PW-1:0] r_phase, w_phase_nxt;
  logic [1:0]    r_slot, w_slot_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;
  logic [1:0]    r_owner, w_owner_nxt, w_grant;
  logic          r_wr, w_wr_nxt;
  logic          w_arb, w_busy;
  logic [16:0]   r_va, w_va_nxt;
  logic [7:0]    r_vdo, w_vdo_nxt;
  logic [7:0]    r_rdata, w_rdata_nxt;
  logic          r_vcs_n, w_vcs_n_nxt;
  logic          r_vwe_n, w_vwe_n_nxt;
  logic          r_disp_valid, w_disp_valid_nxt;
  logic          r_cpu_ack, w_cpu_ack_nxt;
  logic          r_cmd_ack, w_cmd_ack_nxt;
  logic          w_done;

  // Arbitration happens on phase 0 unless a line sync restarts the schedule
  assign w_arb = (r_phase == '0) && !i_LINE_SYNC;

  // State register: phase, slot, starvation count, owner and registered pins
  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_phase      <= '0;
      r_slot       <= '0;
      r_starve     <= '0;
      r_owner      <= OWN_IDLE;
      r_wr         <= 1'b0;
      r_va         <= '0;
      r_vdo        <= '0;
      r_rdata      <= '0;
      r_vcs_n      <= 1'b1;
      r_vwe_n      <= 1'b1;
      r_disp_valid <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_cmd_ack    <= 1'b0;
    end else if (i_XTAL_NCEN) begin
      r_phase      <= w_phase_nxt;
      r_slot       <= w_slot_nxt;
      r_starve     <= w_starve_nxt;
      r_owner      <= w_owner_nxt;
      r_wr         <= w_wr_nxt;
      r_va         <= w_va_nxt;
      r_vdo        <= w_vdo_nxt;
      r_rdata      <= w_rdata_nxt;
      r_vcs_n      <= w_vcs_n_nxt;
      r_vwe_n      <= w_vwe_n_nxt;
      r_disp_valid <= w_disp_valid_nxt;
      r_cpu_ack    <= w_cpu_ack_nxt;
      r_cmd_ack    <= w_cmd_ack_nxt;
    end
  end

  // Next state: owner pick at phase 0, phase/slot advance, line-sync restart
  always_comb begin
    w_grant      = OWN_IDLE;
    w_starve_nxt = r_starve;
    w_phase_nxt  = r_phase + PW'(1);
    w_slot_nxt   = r_slot;
    w_owner_nxt  = r_owner;
    w_wr_nxt     = r_wr;
    if (w_arb) begin
      if (DISP_MASK[r_slot] && i_DISP_ACTIVE) begin
        w_grant = OWN_DISP;
        if (!i_CMD_REQ) w_starve_nxt = '0;
      end else if (i_CMD_REQ && (r_starve == STARVE_MAX)) begin
        w_grant      = OWN_CMD;
        w_starve_nxt = '0;
      end else if (i_CPU_REQ) begin
        w_grant = OWN_CPU;
        if (!i_CMD_REQ) w_starve_nxt = '0;
        else            w_starve_nxt = r_starve + SW'(1);
      end else if (i_CMD_REQ) begin
        w_grant      = OWN_CMD;
        w_starve_nxt = '0;
      end else begin
        w_starve_nxt = '0;
      end
    end
    if (i_LINE_SYNC) begin
      w_phase_nxt = '0;
      w_slot_nxt  = '0;
      w_owner_nxt = OWN_IDLE;
      w_wr_nxt    = 1'b0;
    end else if (w_arb) begin
      w_owner_nxt = w_grant;
      w_wr_nxt    = ((w_grant == OWN_CPU) && i_CPU_WR) || ((w_grant == OWN_CMD) && i_CMD_WR);
    end else if (r_phase == PH_LAST) begin
      w_phase_nxt = '0;
      w_slot_nxt  = r_slot + 2'd1;
      w_owner_nxt = OWN_IDLE;
      w_wr_nxt    = 1'b0;
    end
  end

  // Output values for the phase being entered: strobes, address/data, capture, acks
  always_comb begin
    w_busy      = (w_owner_nxt != OWN_IDLE) && (w_phase_nxt != '0) && (w_phase_nxt <= PH_CAP);
    w_vcs_n_nxt = !w_busy;
    w_vwe_n_nxt = !(w_busy && w_wr_nxt);
    w_va_nxt    = r_va;
    w_vdo_nxt   = r_vdo;
    w_rdata_nxt = r_rdata;
    if (w_arb) begin
      case (w_grant)
        OWN_DISP: w_va_nxt = i_DISP_ADDR;
        OWN_CPU: begin
          w_va_nxt = i_CPU_ADDR;
          if (i_CPU_WR) w_vdo_nxt = i_CPU_WDATA;
        end
        OWN_CMD: begin
          w_va_nxt = i_CMD_ADDR;
          if (i_CMD_WR) w_vdo_nxt = i_CMD_WDATA;
        end
        default: w_va_nxt = r_va;
      endcase
    end
    if (!i_LINE_SYNC && (r_owner != OWN_IDLE) && !r_wr && (r_phase == PH_CAP))
      w_rdata_nxt = i_VDI;
    w_done           = !i_LINE_SYNC && (r_phase == PH_REC);
    w_disp_valid_nxt = w_done && (r_owner == OWN_DISP);
    w_cpu_ack_nxt    = w_done && (r_owner == OWN_CPU);
    w_cmd_ack_nxt    = w_done && (r_owner == OWN_CMD);
  end

`ifdef IKA9958_VRAM_STALL_STAT_EN
  logic [15:0] r_stall_cnt;

  // Count phase-0 decisions that left a pending CPU request ungranted
  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_stall_cnt <= '0;
    end else if (i_XTAL_NCEN) begin
      if (i_STAT_CLR)
        r_stall_cnt <= '0;
      else if (w_arb && i_CPU_REQ && (w_grant != OWN_CPU) && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_CPU_STALL_CNT = r_stall_cnt;
`endif

  assign o_DISP_VALID = r_disp_valid;
  assign o_CPU_ACK    = r_cpu_ack;
  assign o_CMD_ACK    = r_cmd_ack;
  assign o_RDATA      = r_rdata;
  assign o_VA         = r_va;
  assign o_VDO        = r_vdo;
  assign o_VCS_n      = r_vcs_n;
  assign o_VWE_n      = r_vwe_n;
  assign o_SLOT_OWNER = r_owner;

endmodule

// File: tb/tb_ika9958_vram_arbiter.sv
// tb_ika9958_vram_arbiter: directed and randomized checks of the VRAM slot
// arbiter against a slot-level behavioural model.
`timescale 1ns/1ps
module tb_ika9958_vram_arbiter;

  localparam int SLOT_LEN   = 8;
  localparam int CMD_STARVE = 3;
  localparam logic [3:0] DISP_MASK = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        sync = 1'b0;
  logic        disp_act = 1'b0;
  logic [16:0] disp_addr = '0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cmd_req = 1'b0, cmd_wr = 1'b0;
  logic [16:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [7:0]  vdi = '0;
  logic        stat_clr = 1'b0;

  logic        o_DISP_VALID, o_CPU_ACK, o_CMD_ACK, o_VCS_n, o_VWE_n;
  logic [7:0]  o_RDATA, o_VDO;
  logic [16:0] o_VA;
  logic [1:0]  o_SLOT_OWNER;
  logic [15:0] o_CPU_STALL_CNT;

  ika9958_vram_arbiter dut (
    .i_XTAL1        (clk),
    .i_RST_n        (rst_n),
    .i_XTAL_NCEN    (en),
    .i_LINE_SYNC    (sync),
    .i_DISP_ACTIVE  (disp_act),
    .i_DISP_ADDR    (disp_addr),
    .o_DISP_VALID   (o_DISP_VALID),
    .i_CPU_REQ      (cpu_req),
    .i_CPU_WR       (cpu_wr),
    .i_CPU_ADDR     (cpu_addr),
    .i_CPU_WDATA    (cpu_wdata),
    .o_CPU_ACK      (o_CPU_ACK),
    .i_CMD_REQ      (cmd_req),
    .i_CMD_WR       (cmd_wr),
    .i_CMD_ADDR     (cmd_addr),
    .i_CMD_WDATA    (cmd_wdata),
    .o_CMD_ACK      (o_CMD_ACK),
    .o_RDATA        (o_RDATA),
    .o_VA           (o_VA),
    .o_VDO          (o_VDO),
    .i_VDI          (vdi),
    .o_VCS_n        (o_VCS_n),
    .o_VWE_n        (o_VWE_n),
`ifdef IKA9958_VRAM_STALL_STAT_EN
    .i_STAT_CLR     (stat_clr),
    .o_CPU_STALL_CNT(o_CPU_STALL_CNT),
`endif
    .o_SLOT_OWNER   (o_SLOT_OWNER)
  );

`ifndef IKA9958_VRAM_STALL_STAT_EN
  assign o_CPU_STALL_CNT = '0;
`endif

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Behavioural model: where we are inside the slot and who owns it
  int          m_phase, m_slot, m_owner, m_wr, m_starve, m_stall;
  logic [16:0] m_va;
  logic [7:0]  m_vdo, m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_slot = 0; m_owner = 0; m_wr = 0; m_starve = 0; m_stall = 0;
    m_va = '0; m_vdo = '0; m_rdata = '0;
  endtask

  // One enabled clock edge seen at slot granularity
  task automatic model_edge();
    int g;
    g = -1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!en) return;
    if (sync) begin
      m_phase = 0; m_slot = 0; m_owner = 0; m_wr = 0;
    end else if (m_phase == 0) begin
      if (DISP_MASK[m_slot] && disp_act)          g = 1;
      else if (cmd_req && m_starve == CMD_STARVE) g = 3;
      else if (cpu_req)                           g = 2;
      else if (cmd_req)                           g = 3;
      else                                        g = 0;
      if (g == 3 || !cmd_req) m_starve = 0;
      else if (g == 2)        m_starve = (m_starve + 1 > CMD_STARVE) ? CMD_STARVE : m_starve + 1;
      m_owner = g;
      m_phase = 1;
      m_wr    = 0;
      if (g == 1) m_va = disp_addr;
      if (g == 2) begin m_va = cpu_addr; m_wr = int'(cpu_wr); if (cpu_wr) m_vdo = cpu_wdata; end
      if (g == 3) begin m_va = cmd_addr; m_wr = int'(cmd_wr); if (cmd_wr) m_vdo = cmd_wdata; end
    end else begin
      if (m_phase == SLOT_LEN - 3 && m_owner != 0 && m_wr == 0) m_rdata = vdi;
      m_phase++;
      if (m_phase == SLOT_LEN) begin
        m_phase = 0; m_slot = (m_slot + 1) % 4; m_owner = 0; m_wr = 0;
      end
    end
`ifdef IKA9958_VRAM_STALL_STAT_EN
    if (stat_clr) m_stall = 0;
    else if (g >= 0 && cpu_req && g != 2 && m_stall < 65535) m_stall++;
`endif
  endtask

  task automatic check_outputs();
    logic act;
    act = (m_owner != 0) && (m_phase >= 1) && (m_phase <= SLOT_LEN - 3);
    check("vcs_n",      32'(o_VCS_n),      32'(!act));
    check("vwe_n",      32'(o_VWE_n),      32'(!(act && m_wr != 0)));
    check("slot_owner", 32'(o_SLOT_OWNER), 32'(m_owner));
    check("disp_valid", 32'(o_DISP_VALID), 32'(m_phase == SLOT_LEN - 1 && m_owner == 1));
    check("cpu_ack",    32'(o_CPU_ACK),    32'(m_phase == SLOT_LEN - 1 && m_owner == 2));
    check("cmd_ack",    32'(o_CMD_ACK),    32'(m_phase == SLOT_LEN - 1 && m_owner == 3));
    check("va",         32'(o_VA),         32'(m_va));
    check("vdo",        32'(o_VDO),        32'(m_vdo));
    check("rdata",      32'(o_RDATA),      32'(m_rdata));
`ifdef IKA9958_VRAM_STALL_STAT_EN
    check("stall_cnt",  32'(o_CPU_STALL_CNT), 32'(m_stall));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    en = 1'b1; sync = 1'b0; disp_act = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    vdi = '0; stat_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  int cnt;
  int k;
  bit got;
  bit cpu_ack_q, cmd_ack_q;

  initial begin
    model_reset();
    idle_inputs();
    @(negedge clk);

    // Reset state and 16 idle slots
    do_reset();
    check("rst_vcs_n", 32'(o_VCS_n), 32'd1);
    check("rst_vwe_n", 32'(o_VWE_n), 32'd1);
    check("rst_owner", 32'(o_SLOT_OWNER), 32'd0);
    check("rst_va", 32'(o_VA), 32'd0);
    check("rst_rdata", 32'(o_RDATA), 32'd0);
    cnt = 0;
    repeat (16 * SLOT_LEN) begin
      tick();
      if (o_VCS_n !== 1'b1) cnt++;
      if (o_DISP_VALID || o_CPU_ACK || o_CMD_ACK || o_SLOT_OWNER != 2'd0) cnt++;
    end
    check("idle_activity", 32'(cnt), 32'd0);

    // Display owns masked slots 0..2, slot 3 idle
    do_reset();
    disp_act = 1'b1; disp_addr = 17'h1ABCD; vdi = 8'h5A;
    repeat (8 * SLOT_LEN) begin
      tick();
      if (m_phase == 1) check("disp_owner", 32'(o_SLOT_OWNER), (m_slot == 3) ? 32'd0 : 32'd1);
      if (m_phase == 6 && m_slot != 3) check("disp_va", 32'(o_VA), 32'h1ABCD);
      if (m_phase == 7) begin
        check("disp_valid_ph7", 32'(o_DISP_VALID), (m_slot == 3) ? 32'd0 : 32'd1);
        check("disp_rdata", 32'(o_RDATA), 32'h5A);
      end
    end
    idle_inputs();

    // CPU write in the first slot
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h00010; cpu_wdata = 8'hC3;
    cnt = 0; got = 1'b0;
    while (!got && cnt < 40) begin
      tick();
      cnt++;
      if (m_phase >= 1 && m_phase <= 5) begin
        check("cpuwr_vwe_n", 32'(o_VWE_n), 32'd0);
        check("cpuwr_vdo", 32'(o_VDO), 32'hC3);
      end
      if (o_CPU_ACK) got = 1'b1;
    end
    check("cpuwr_ack_latency", 32'(cnt), 32'd7);
    cpu_req = 1'b0;
    tick();
    check("cpuwr_ack_one_phase", 32'(o_CPU_ACK), 32'd0);

    // CPU and CMD continuously pending: CPU x3 then forced CMD
    do_reset();
    cpu_req = 1'b1; cpu_addr = 17'h00100;
    cmd_req = 1'b1; cmd_addr = 17'h00200;
    k = 0;
    repeat (8 * SLOT_LEN) begin
      tick();
      if (m_phase == 1) begin
        check("starve_seq", 32'(o_SLOT_OWNER), ((k % 4) == 3) ? 32'd3 : 32'd2);
        k++;
      end
    end
    idle_inputs();

    // Line sync aborts a CPU read at phase 3; the CPU is re-granted
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00123; vdi = 8'h77;
    repeat (3) tick();
    check("sync_pre_vcs_n", 32'(o_VCS_n), 32'd0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_vcs_n", 32'(o_VCS_n), 32'd1);
    check("sync_owner", 32'(o_SLOT_OWNER), 32'd0);
    cnt = 1; got = 1'b0;
    while (!got && cnt < 40) begin
      tick();
      cnt++;
      if (o_CPU_ACK) got = 1'b1;
    end
    check("sync_reack_latency", 32'(cnt), 32'd8);
    check("sync_rdata", 32'(o_RDATA), 32'h77);
    cpu_req = 1'b0;

    // Async reset in the middle of a CMD write
    do_reset();
    cmd_req = 1'b1; cmd_wr = 1'b1; cmd_addr = 17'h1F000; cmd_wdata = 8'h3C;
    repeat (4) tick();
    check("arst_pre_vwe_n", 32'(o_VWE_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_vcs_n", 32'(o_VCS_n), 32'd1);
    check("arst_vwe_n", 32'(o_VWE_n), 32'd1);
    check("arst_cmd_ack", 32'(o_CMD_ACK), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_regrant", 32'(o_SLOT_OWNER), 32'd3);
    cnt = 1; got = 1'b0;
    while (!got && cnt < 40) begin
      tick();
      cnt++;
      if (o_CMD_ACK) got = 1'b1;
    end
    check("arst_ack_latency", 32'(cnt), 32'd7);
    idle_inputs();

    // Randomized traffic with enable gaps, line syncs and display windows
    do_reset();
    cpu_ack_q = 1'b0; cmd_ack_q = 1'b0;
    repeat (3000) begin
      tick();
      en        = ($urandom_range(0, 9) != 0);
      sync      = ($urandom_range(0, 199) == 0);
      stat_clr  = ($urandom_range(0, 99) == 0);
      vdi       = 8'($urandom);
      disp_addr = 17'($urandom);
      if ($urandom_range(0, 49) == 0) disp_act = ~disp_act;
      if (cpu_req) begin
        if (o_CPU_ACK && !cpu_ack_q) begin
          cpu_req = ($urandom_range(0, 1) == 1);
          cpu_wr = 1'($urandom); cpu_addr = 17'($urandom); cpu_wdata = 8'($urandom);
        end else if (!o_CPU_ACK && m_owner != 2 && $urandom_range(0, 39) == 0) begin
          cpu_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        cpu_req = 1'b1;
        cpu_wr = 1'($urandom); cpu_addr = 17'($urandom); cpu_wdata = 8'($urandom);
      end
      if (cmd_req) begin
        if (o_CMD_ACK && !cmd_ack_q) begin
          cmd_req = ($urandom_range(0, 1) == 1);
          cmd_wr = 1'($urandom); cmd_addr = 17'($urandom); cmd_wdata = 8'($urandom);
        end else if (!o_CMD_ACK && m_owner != 3 && $urandom_range(0, 39) == 0) begin
          cmd_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cmd_req = 1'b1;
        cmd_wr = 1'($urandom); cmd_addr = 17'($urandom); cmd_wdata = 8'($urandom);
      end
      cpu_ack_q = o_CPU_ACK;
      cmd_ack_q = o_CMD_ACK;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
